// File: rtl/phy_pkg.sv
// ----------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the phy_tx lane logic.
//   DATA_W_DEFAULT : default byte-lane width
//   LANE0 / LANE1  : lane index values carried on out_lane and held in sel
// ----------------------------------------------------------------------------
package phy_pkg;

   localparam int DATA_W_DEFAULT = 8;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

endpackage

// File: rtl/lane_fifo.sv
// ----------------------------------------------------------------------------
// lane_fifo
// Synchronous single-clock FIFO buffering one byte lane.
// Ports:
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push, din  : write din on the rising edge when push is high and not full
//   pop        : drop the head entry on the rising edge when not empty
//   dout       : head entry, combinational (valid whenever empty is low)
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module lane_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible past the pointers.
   always_ff @(posedge clk) begin
      if (do_push && !reset) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/mux2x1_tx.sv
// ----------------------------------------------------------------------------
// mux2x1_tx
// Transmit-side 2:1 lane multiplexer: merges two byte lanes into one byte
// stream running at twice the per-lane rate, ahead of the serializer.
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   in0_* / in1_*           : per-lane valid/ready byte inputs
//   out_data/out_valid      : registered merged byte and its valid flag
//   out_lane                : lane the current out_data came from
//   fifo0_count/fifo1_count : per-lane FIFO occupancy
// STRICT_ALT=1 gives each lane fixed alternating slots (empty slot idles);
// STRICT_ALT=0 hands an empty lane's slot to the other lane.
// ----------------------------------------------------------------------------
module mux2x1_tx
   import phy_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEFAULT,
   parameter int DEPTH      = 4,
   parameter bit STRICT_ALT = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [DATA_W-1:0]        in0_data,
   input  logic                     in0_valid,
   output logic                     in0_ready,
   input  logic [DATA_W-1:0]        in1_data,
   input  logic                     in1_valid,
   output logic                     in1_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   output logic                     out_lane,
   output logic [$clog2(DEPTH):0]   fifo0_count,
   output logic [$clog2(DEPTH):0]   fifo1_count
);

   logic              full0, full1;
   logic              empty0, empty1;
   logic [DATA_W-1:0] head0, head1;
   logic              push0, push1;
   logic              pop0, pop1;

   logic              sel;
   logic              sel_next;
   logic [DATA_W-1:0] data_next;
   logic              valid_next;
   logic              lane_next;

   // Ready looks only at the stored count, so a same-cycle pop never frees a slot early.
   assign in0_ready = !reset && !full0;
   assign in1_ready = !reset && !full1;
   assign push0     = in0_valid && in0_ready;
   assign push1     = in1_valid && in1_ready;

   lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo0 (
      .clk   (clk),
      .reset (reset),
      .push  (push0),
      .pop   (pop0),
      .din   (in0_data),
      .dout  (head0),
      .full  (full0),
      .empty (empty0),
      .count (fifo0_count)
   );

   lane_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo1 (
      .clk   (clk),
      .reset (reset),
      .push  (push1),
      .pop   (pop1),
      .din   (in1_data),
      .dout  (head1),
      .full  (full1),
      .empty (empty1),
      .count (fifo1_count)
   );

   // Slot selector. In work-conserving mode a borrowed slot leaves sel
   // unchanged, so the skipped lane keeps first claim on the next cycle.
   always_comb begin
      pop0       = 1'b0;
      pop1       = 1'b0;
      sel_next   = sel;
      data_next  = '0;
      valid_next = 1'b0;
      lane_next  = sel;
      if (STRICT_ALT) begin
         sel_next = ~sel;
         if (sel == LANE0 && !empty0) begin
            pop0       = 1'b1;
            data_next  = head0;
            valid_next = 1'b1;
         end else if (sel == LANE1 && !empty1) begin
            pop1       = 1'b1;
            data_next  = head1;
            valid_next = 1'b1;
         end
      end else begin
         if (sel == LANE0 && !empty0) begin
            pop0       = 1'b1;
            data_next  = head0;
            valid_next = 1'b1;
            lane_next  = LANE0;
            sel_next   = LANE1;
         end else if (sel == LANE1 && !empty1) begin
            pop1       = 1'b1;
            data_next  = head1;
            valid_next = 1'b1;
            lane_next  = LANE1;
            sel_next   = LANE0;
         end else if (!empty0) begin
            pop0       = 1'b1;
            data_next  = head0;
            valid_next = 1'b1;
            lane_next  = LANE0;
         end else if (!empty1) begin
            pop1       = 1'b1;
            data_next  = head1;
            valid_next = 1'b1;
            lane_next  = LANE1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel       <= LANE0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_lane  <= LANE0;
      end else begin
         sel       <= sel_next;
         out_data  <= data_next;
         out_valid <= valid_next;
         out_lane  <= lane_next;
      end
   end

endmodule

// File: tb/tb_mux2x1_tx.sv
// ----------------------------------------------------------------------------
// tb_mux2x1_tx
// Self-checking bench for mux2x1_tx. Two instances are built, one strict
// (STRICT_ALT=1) and one work-conserving (STRICT_ALT=0); 'mode' routes the
// bench stimulus to one of them and selects which outputs are observed.
// ----------------------------------------------------------------------------
module tb_mux2x1_tx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       mode = 1'b0;
   logic [7:0] in0_data = '0;
   logic       in0_valid = 1'b0;
   logic [7:0] in1_data = '0;
   logic       in1_valid = 1'b0;

   logic       in0_ready, in1_ready, out_valid, out_lane;
   logic [7:0] out_data;
   logic [2:0] fifo0_count, fifo1_count;

   logic       s_in0_valid, s_in1_valid, s_in0_ready, s_in1_ready, s_out_valid, s_out_lane;
   logic       w_in0_valid, w_in1_valid, w_in0_ready, w_in1_ready, w_out_valid, w_out_lane;
   logic [7:0] s_out_data, w_out_data;
   logic [2:0] s_cnt0, s_cnt1, w_cnt0, w_cnt1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign s_in0_valid = in0_valid && (mode == 1'b0);
   assign s_in1_valid = in1_valid && (mode == 1'b0);
   assign w_in0_valid = in0_valid && (mode == 1'b1);
   assign w_in1_valid = in1_valid && (mode == 1'b1);

   assign in0_ready   = mode ? w_in0_ready : s_in0_ready;
   assign in1_ready   = mode ? w_in1_ready : s_in1_ready;
   assign out_data    = mode ? w_out_data  : s_out_data;
   assign out_valid   = mode ? w_out_valid : s_out_valid;
   assign out_lane    = mode ? w_out_lane  : s_out_lane;
   assign fifo0_count = mode ? w_cnt0      : s_cnt0;
   assign fifo1_count = mode ? w_cnt1      : s_cnt1;

   mux2x1_tx #(.DATA_W(8), .DEPTH(4), .STRICT_ALT(1'b1)) dut_strict (
      .clk         (clk),
      .reset       (reset),
      .in0_data    (in0_data),
      .in0_valid   (s_in0_valid),
      .in0_ready   (s_in0_ready),
      .in1_data    (in1_data),
      .in1_valid   (s_in1_valid),
      .in1_ready   (s_in1_ready),
      .out_data    (s_out_data),
      .out_valid   (s_out_valid),
      .out_lane    (s_out_lane),
      .fifo0_count (s_cnt0),
      .fifo1_count (s_cnt1)
   );

   mux2x1_tx #(.DATA_W(8), .DEPTH(4), .STRICT_ALT(1'b0)) dut_wc (
      .clk         (clk),
      .reset       (reset),
      .in0_data    (in0_data),
      .in0_valid   (w_in0_valid),
      .in0_ready   (w_in0_ready),
      .in1_data    (in1_data),
      .in1_valid   (w_in1_valid),
      .in1_ready   (w_in1_ready),
      .out_data    (w_out_data),
      .out_valid   (w_out_valid),
      .out_lane    (w_out_lane),
      .fifo0_count (w_cnt0),
      .fifo1_count (w_cnt1)
   );

   typedef struct {
      logic       mode;
      logic       rst;
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       e_valid;
      logic [7:0] e_data;
      logic       e_lane;
      logic [2:0] e_c0;
      logic [2:0] e_c1;
      logic       e_r0;
      logic       e_r1;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic m, input logic r,
                               input logic v0, input logic [7:0] d0,
                               input logic v1, input logic [7:0] d1,
                               input logic ev, input logic [7:0] ed, input logic el,
                               input logic [2:0] c0, input logic [2:0] c1);
      vec_t v;
      v.mode = m;  v.rst = r;
      v.v0 = v0;   v.d0 = d0;
      v.v1 = v1;   v.d1 = d1;
      v.e_valid = ev; v.e_data = ed; v.e_lane = el;
      v.e_c0 = c0; v.e_c1 = c1;
      v.e_r0 = !r; v.e_r1 = !r;
      return v;
   endfunction

   task automatic checkOutput(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge.
   task automatic applyStimulus(input logic m, input logic r,
                                input logic v0, input logic [7:0] d0,
                                input logic v1, input logic [7:0] d1);
      mode      = m;
      reset     = r;
      in0_valid = v0;
      in0_data  = d0;
      in1_valid = v1;
      in1_data  = d1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int sent;
      int recv;
      int cycles;
      int max_cnt;
      bit saw_stall;
      bit accepted;
      logic [7:0] exp_byte;

      // Reset held with both lanes valid
      repeat (3) vecs.push_back(mk(0, 1, 1, 8'hFF, 1, 8'hEE, 0, 8'h00, 0, 0, 0));
      // Strict interleave, pushes every other cycle
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'hA0, 1, 8'hB0, 0, 8'h00, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA1, 1, 8'hB1, 1, 8'hB0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 1, 8'hA2, 1, 8'hB2, 1, 8'hB1, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA2, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hB2, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      // Strict idle slot: lane 0 only, back-to-back
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'h11, 0, 8'h00, 0, 8'h00, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 8'h22, 0, 8'h00, 0, 8'h00, 1, 2, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h11, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h22, 0, 0, 0));
      // Work-conserving: same stimulus, no idle slot between 11 and 22
      vecs.push_back(mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 8'h11, 0, 8'h00, 0, 8'h00, 0, 1, 0));
      vecs.push_back(mk(1, 0, 1, 8'h22, 0, 8'h00, 1, 8'h11, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h22, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      // Mid-operation reset with three bytes buffered in lane 0
      vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'h01, 0, 8'h00, 0, 8'h00, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 8'h02, 0, 8'h00, 0, 8'h00, 1, 2, 0));
      vecs.push_back(mk(0, 0, 1, 8'h03, 0, 8'h00, 1, 8'h01, 0, 2, 0));
      vecs.push_back(mk(0, 0, 1, 8'h04, 0, 8'h00, 0, 8'h00, 1, 3, 0));
      vecs.push_back(mk(0, 1, 1, 8'h05, 0, 8'h00, 0, 8'h00, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h5A, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].mode, vecs[i].rst, vecs[i].v0, vecs[i].d0,
                       vecs[i].v1, vecs[i].d1);
         checkOutput("out_valid", i, 32'(out_valid), 32'(vecs[i].e_valid));
         checkOutput("out_data", i, 32'(out_data), 32'(vecs[i].e_data));
         if (vecs[i].e_valid || vecs[i].mode == 1'b0) begin
            checkOutput("out_lane", i, 32'(out_lane), 32'(vecs[i].e_lane));
         end
         checkOutput("fifo0_count", i, 32'(fifo0_count), 32'(vecs[i].e_c0));
         checkOutput("fifo1_count", i, 32'(fifo1_count), 32'(vecs[i].e_c1));
         checkOutput("in0_ready", i, 32'(in0_ready), 32'(vecs[i].e_r0));
         checkOutput("in1_ready", i, 32'(in1_ready), 32'(vecs[i].e_r1));
      end

      // Backpressure: lane 1 offers C0..C7 every cycle into the strict instance
      applyStimulus(0, 1, 0, 8'h00, 0, 8'h00);
      sent      = 0;
      recv      = 0;
      cycles    = 0;
      max_cnt   = 0;
      saw_stall = 1'b0;
      while (recv < 8 && cycles < 100) begin
         mode      = 1'b0;
         reset     = 1'b0;
         in0_valid = 1'b0;
         in1_valid = (sent < 8);
         in1_data  = 8'hC0 + 8'(sent);
         #1;
         accepted = in1_valid && in1_ready;
         if (in1_valid && !in1_ready) begin
            saw_stall = 1'b1;
            checkOutput("bp_stall_count", cycles, 32'(fifo1_count), 32'd4);
         end
         @(posedge clk);
         #1;
         if (accepted) sent++;
         if (int'(fifo1_count) > max_cnt) max_cnt = int'(fifo1_count);
         if (out_valid) begin
            exp_byte = 8'hC0 + 8'(recv);
            checkOutput("bp_data", recv, 32'(out_data), 32'(exp_byte));
            checkOutput("bp_lane", recv, 32'(out_lane), 32'd1);
            recv++;
         end
         cycles++;
      end
      checkOutput("bp_received", 0, 32'(recv), 32'd8);
      checkOutput("bp_max_count", 0, 32'(max_cnt), 32'd4);
      checkOutput("bp_saw_stall", 0, 32'(saw_stall), 32'd1);
      in1_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_no_extra", i, 32'(out_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux2x1_tx.md
Name: mux2x1_tx

Overview:
Transmit-side 2:1 lane multiplexer: merges two byte lanes into a single byte stream at clk, which is twice the per-lane rate. It is the inverse of the receive-side 1:2 demux.
- Each lane is buffered in a small FIFO with a valid/ready handshake.
- A round-robin selector emits lane 0 and lane 1 bytes alternately.
- It sits in phy_tx, ahead of the serializer.

Parameters:
DATA_W, 8, lane and output data width
DEPTH, 4, entries per lane FIFO; power of 2, minimum 2
STRICT_ALT, 1, 1 = fixed alternating slots (an empty slot is left idle); 0 = work-conserving (an empty lane's slot is given to the other lane)

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in0_data  in  DATA_W  lane 0 byte
in0_valid  in  1  lane 0 byte valid
in0_ready  out  1  lane 0 FIFO can accept
in1_data  in  DATA_W  lane 1 byte
in1_valid  in  1  lane 1 byte valid
in1_ready  out  1  lane 1 FIFO can accept
out_data  out  DATA_W  merged byte, registered
out_valid  out  1  out_data holds a real byte this cycle
out_lane  out  1  source lane of out_data
fifo0_count  out  $clog2(DEPTH)+1  lane 0 occupancy
fifo1_count  out  $clog2(DEPTH)+1  lane 1 occupancy

Behaviour:
Reset (reset=1 at a clk edge):
- Both FIFOs emptied; counts 0.
- sel=0, out_data=0, out_valid=0, out_lane=0.
- inN_ready=0 while reset is high.
- Reset mid-operation discards all buffered bytes; there is no partial drain.

Input side:
- inN_ready = !reset && (countN != DEPTH). It depends on count only; a pop in the same cycle does not free a slot early.
- Push on the edge where inN_valid && inN_ready.
- inN_valid while not ready: the byte is not taken; the source must hold it.

Selector, evaluated every cycle after reset:
- STRICT_ALT=1:
  - If FIFO[sel] is non-empty: pop it; out_data <= head, out_valid <= 1, out_lane <= sel.
  - Otherwise: out_data <= 0, out_valid <= 0, out_lane <= sel.
  - sel <= ~sel unconditionally, so lane 0 always owns even cycles after reset.
- STRICT_ALT=0:
  - If FIFO[sel] is non-empty: serve sel, then sel <= ~sel.
  - Else if FIFO[~sel] is non-empty: serve ~sel; sel stays unchanged (sel now points at the lane not served).
  - Else: idle (out_data=0, out_valid=0); sel unchanged.

Timing and FIFO rules:
- Latency: a byte pushed at edge N into an empty FIFO reaches out_data at edge N+1 at the earliest, if its lane owns slot N+1. Worst case is N+2 in strict mode.
- Simultaneous push and pop on one FIFO: count unchanged; data order preserved.
- Pointers wrap modulo DEPTH.
- No overflow is possible because of the ready gating. Popping an empty FIFO never occurs.
- Output order within a lane is strictly FIFO. Across lanes the order is strictly alternate when both lanes are backlogged.

Sustained rates:
- With both lanes backlogged, throughput is 1 byte/clk at the output and 1 byte per 2 clk per lane.
- A lane pushing every cycle fills its FIFO: ready deasserts at count=DEPTH and sustains 1/2 rate.

Decomposition:
- Shared package phy_pkg:
  - DATA_W default.
  - Lane index constants LANE0=0, LANE1=1.
- One sub-module: lane_fifo.
  - Synchronous FIFO, parameterized DATA_W and DEPTH.
  - Ports: push, pop, din, dout (head, combinational), full, empty, count.
  - Instantiated twice.
- The top level holds the selector and the output register.

Test Plan:
1. Reset check: hold reset 3 cycles with both lanes valid -> out_valid=0, out_data=0, in0_ready=in1_ready=0, counts=0.
2. Interleave: STRICT_ALT=1. Push lane0 bytes 0xA0,0xA1,0xA2 and lane1 bytes 0xB0,0xB1,0xB2 every other cycle after reset -> out_data sequence A0,B0,A1,B1,A2,B2 with out_lane 0,1,0,1,0,1.
3. Strict idle slot: STRICT_ALT=1, only lane0 pushes 0x11,0x22 back-to-back -> output 11, idle, 22 (out_valid 1,0,1).
4. Work-conserving: same stimulus as scenario 3 with STRICT_ALT=0 -> 11,22 on consecutive cycles, no idle slot.
5. Backpressure: lane1 pushes 0xC0-0xC7 every cycle with DEPTH=4 -> in1_ready drops when fifo1_count=4; all 8 bytes emerge in order with none lost or duplicated.
6. Mid-operation reset: reset asserted with fifo0_count=3 -> next cycle counts=0 and out_valid=0. After release, a new byte 0x5A is the first output, with out_lane=0.
